// File: rtl/renkon_linebuf_feeder_pkg.sv
// Shared widths, feeder state encoding and address-width helper for the
// renkon line-buffer feeder slice.
package renkon_linebuf_feeder_pkg;

  localparam int unsigned DWIDTH = 16;
  localparam int unsigned LWIDTH = 10;
  localparam int unsigned STEP   = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAITLOW,
    S_FEED
  } feeder_state_t;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/renkon_linebuf_feeder_if.sv
// Controller, feature-map memory and line-buffer signals of the feeder.
// master = feeder side, slave = environment (controller/memory/linebuf).
interface renkon_linebuf_feeder_if
  import renkon_linebuf_feeder_pkg::*;
#(
  parameter int unsigned MEMSIZE = 65536
);
  localparam int unsigned AWIDTH = addr_width(MEMSIZE);

  logic                     req;
  logic                     ack;
  logic [LWIDTH-1:0]        img_size;
  logic [AWIDTH-1:0]        base_addr;
  logic [AWIDTH-1:0]        mem_addr;
  logic signed [DWIDTH-1:0] mem_rdata;
  logic                     buf_req;
  logic                     buf_ack;
  logic                     buf_ready;
  logic signed [DWIDTH-1:0] buf_input;

  modport master (
    input  req, img_size, base_addr, mem_rdata, buf_ack, buf_ready,
    output ack, mem_addr, buf_req, buf_input
  );

  modport slave (
    output req, img_size, base_addr, mem_rdata, buf_ack, buf_ready,
    input  ack, mem_addr, buf_req, buf_input
  );

endinterface

// File: rtl/renkon_linebuf_feeder.sv
// Streams a feature map from 1-cycle-latency memory into the padded line
// buffer, one pixel per buf_ready, with address lookahead for zero bubbles.
module renkon_linebuf_feeder
  import renkon_linebuf_feeder_pkg::*;
#(
  parameter int unsigned IMAGE   = 32,
  parameter int unsigned MEMSIZE = 65536
)(
  input  logic                    clk,
  input  logic                    xrst,
  renkon_linebuf_feeder_if.master bus
);

  localparam int unsigned AWIDTH = addr_width(MEMSIZE);
  localparam int unsigned CWIDTH = $clog2(IMAGE * IMAGE + 1);

  feeder_state_t      state, state_nx;
  logic [CWIDTH-1:0]  cnt;
  logic [CWIDTH-1:0]  total;
  logic [AWIDTH-1:0]  base;
  logic [2*LWIDTH-1:0] size_ext;
  logic [2*LWIDTH-1:0] prod;
  logic               busy;
  logic               running;
  logic               adv;

  assign size_ext = {{LWIDTH{1'b0}}, bus.img_size};
  assign prod     = size_ext * size_ext;
  assign busy     = (state != S_IDLE);
  assign running  = (cnt < total);
  // The memory registers mem_addr, so a pixel consumed now must already have
  // its successor's address on the bus in the same cycle.
  assign adv      = busy && bus.buf_ready && running;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (bus.req)      state_nx = S_ISSUE;
      S_ISSUE:                     state_nx = S_WAITLOW;
      S_WAITLOW: if (!bus.buf_ack) state_nx = S_FEED;
      S_FEED:    if (bus.buf_ack)  state_nx = S_IDLE;
      default:                     state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ack       = (state == S_IDLE);
    bus.buf_req   = (state == S_ISSUE);
    bus.mem_addr  = base + AWIDTH'(cnt) + AWIDTH'(adv);
    bus.buf_input = running ? bus.mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      cnt   <= '0;
      total <= '0;
      base  <= '0;
    end else if (state == S_IDLE && bus.req) begin
      base  <= bus.base_addr;
      total <= prod[CWIDTH-1:0];
      cnt   <= '0;
    end else if (adv) begin
      cnt   <= cnt + CWIDTH'(1);
    end
  end

endmodule

// File: tb/tb_renkon_linebuf_feeder.sv
// Directed bench for renkon_linebuf_feeder with a 1-cycle-read memory model
// and a hand-driven line-buffer handshake.
module tb_renkon_linebuf_feeder;
  import renkon_linebuf_feeder_pkg::*;

  logic clk;
  logic xrst;
  int   total_n;
  int   bad_n;

  logic signed [DWIDTH-1:0] mem [0:65535];

  renkon_linebuf_feeder_if #(.MEMSIZE(65536)) if_b ();

  renkon_linebuf_feeder #(.IMAGE(32), .MEMSIZE(65536)) u_dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if_b.mem_rdata <= mem[if_b.mem_addr];

  // Pulses req for one cycle; returns at the negedge where the feeder is in S_ISSUE.
  task automatic start_xfer(input int size, input int base);
    @(negedge clk);
    if_b.req       = 1'b1;
    if_b.img_size  = LWIDTH'(size);
    if_b.base_addr = 16'(base);
    if_b.buf_ready = 1'b0;
    @(negedge clk);
    if_b.req       = 1'b0;
  endtask

  task automatic test_reset();
    xrst = 1'b0;
    if_b.req = 1'b0; if_b.buf_ready = 1'b0; if_b.buf_ack = 1'b1;
    if_b.img_size = '0; if_b.base_addr = '0;
    repeat (3) @(negedge clk);
    xrst = 1'b1;
    @(negedge clk); #1;
    total_n++; if (if_b.ack !== 1'b1) begin bad_n++; $display("FAIL rst_ack: got %b want 1", if_b.ack); end
    total_n++; if (if_b.buf_req !== 1'b0) begin bad_n++; $display("FAIL rst_buf_req: got %b want 0", if_b.buf_req); end
    total_n++; if (if_b.buf_input !== '0) begin bad_n++; $display("FAIL rst_buf_input: got %0d want 0", if_b.buf_input); end
    total_n++; if (if_b.mem_addr !== '0) begin bad_n++; $display("FAIL rst_mem_addr: got %0d want 0", if_b.mem_addr); end
  endtask

  task automatic test_stream_full();
    int p;
    int peak;
    int exp_d;
    int exp_a;
    start_xfer(4, 100);
    #1;
    total_n++; if (if_b.buf_req !== 1'b1) begin bad_n++; $display("FAIL full_buf_req: got %b want 1", if_b.buf_req); end
    total_n++; if (if_b.ack !== 1'b0) begin bad_n++; $display("FAIL full_ack_busy: got %b want 0", if_b.ack); end
    total_n++; if (if_b.mem_addr !== 16'd100) begin bad_n++; $display("FAIL full_issue_addr: got %0d want 100", if_b.mem_addr); end
    // stale high buf_ack for one S_WAITLOW cycle must not end the transfer
    @(negedge clk); #1;
    total_n++; if (if_b.buf_input !== 16'sd1) begin bad_n++; $display("FAIL full_pix0_early: got %0d want 1", if_b.buf_input); end
    @(negedge clk);
    if_b.buf_ack = 1'b0; if_b.buf_ready = 1'b1;
    p = 0; peak = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      exp_d = (p < 16) ? p + 1 : 0;
      exp_a = 100 + p + ((p < 16) ? 1 : 0);
      if (int'(if_b.mem_addr) > peak) peak = int'(if_b.mem_addr);
      total_n++; if (if_b.buf_input !== DWIDTH'(exp_d)) begin bad_n++; $display("FAIL full_pix[%0d]: got %0d want %0d", c, if_b.buf_input, exp_d); end
      total_n++; if (if_b.mem_addr !== 16'(exp_a)) begin bad_n++; $display("FAIL full_addr[%0d]: got %0d want %0d", c, if_b.mem_addr, exp_a); end
      if (p < 16) p++;
      @(negedge clk);
    end
    total_n++; if (peak !== 116) begin bad_n++; $display("FAIL full_peak_addr: got %0d want 116", peak); end
    if_b.buf_ready = 1'b0; if_b.buf_ack = 1'b1;
    #1;
    total_n++; if (if_b.ack !== 1'b0) begin bad_n++; $display("FAIL full_ack_pre: got %b want 0", if_b.ack); end
    @(negedge clk); #1;
    total_n++; if (if_b.ack !== 1'b1) begin bad_n++; $display("FAIL full_ack_lat: got %b want 1", if_b.ack); end
  endtask

  task automatic test_stream_toggle();
    int p;
    int exp_d;
    int exp_a;
    logic rdy;
    start_xfer(4, 100);
    @(negedge clk);
    if_b.buf_ack = 1'b0;
    p = 0;
    for (int c = 0; c < 40; c++) begin
      rdy = (c % 2 == 0);
      if_b.buf_ready = rdy;
      #1;
      exp_d = (p < 16) ? p + 1 : 0;
      exp_a = 100 + p + ((rdy && p < 16) ? 1 : 0);
      total_n++; if (if_b.buf_input !== DWIDTH'(exp_d)) begin bad_n++; $display("FAIL tog_pix[%0d]: got %0d want %0d", c, if_b.buf_input, exp_d); end
      total_n++; if (if_b.mem_addr !== 16'(exp_a)) begin bad_n++; $display("FAIL tog_addr[%0d]: got %0d want %0d", c, if_b.mem_addr, exp_a); end
      if (rdy && p < 16) p++;
      @(negedge clk);
    end
    if_b.buf_ready = 1'b0; if_b.buf_ack = 1'b1;
    @(negedge clk); #1;
    total_n++; if (if_b.ack !== 1'b1) begin bad_n++; $display("FAIL tog_ack: got %b want 1", if_b.ack); end
  endtask

  task automatic test_double_req();
    int p;
    int exp_d;
    start_xfer(4, 100);
    @(negedge clk);
    if_b.buf_ack = 1'b0; if_b.buf_ready = 1'b1;
    p = 0;
    for (int c = 0; c < 20; c++) begin
      if_b.req = (c == 0 || c == 9);
      if_b.base_addr = 16'd500; if_b.img_size = LWIDTH'(2);
      #1;
      exp_d = (p < 16) ? p + 1 : 0;
      total_n++; if (if_b.buf_input !== DWIDTH'(exp_d)) begin bad_n++; $display("FAIL dreq_pix[%0d]: got %0d want %0d", c, if_b.buf_input, exp_d); end
      if (p < 16) p++;
      @(negedge clk);
    end
    if_b.req = 1'b0; if_b.buf_ready = 1'b0; if_b.buf_ack = 1'b1;
    @(negedge clk); #1;
    total_n++; if (if_b.ack !== 1'b1) begin bad_n++; $display("FAIL dreq_ack: got %b want 1", if_b.ack); end
  endtask

  task automatic test_zero_size();
    start_xfer(0, 100);
    #1;
    total_n++; if (if_b.buf_req !== 1'b1) begin bad_n++; $display("FAIL zero_buf_req: got %b want 1", if_b.buf_req); end
    @(negedge clk);
    if_b.buf_ack = 1'b0; if_b.buf_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total_n++; if (if_b.buf_input !== '0) begin bad_n++; $display("FAIL zero_pix[%0d]: got %0d want 0", c, if_b.buf_input); end
      total_n++; if (if_b.mem_addr !== 16'd100) begin bad_n++; $display("FAIL zero_addr[%0d]: got %0d want 100", c, if_b.mem_addr); end
      @(negedge clk);
    end
    if_b.buf_ready = 1'b0; if_b.buf_ack = 1'b1;
    @(negedge clk); #1;
    total_n++; if (if_b.ack !== 1'b1) begin bad_n++; $display("FAIL zero_ack: got %b want 1", if_b.ack); end
  endtask

  // Linebuf finishes after 3 pixels; the leftover count must then ignore buf_ready.
  task automatic test_idle_ready();
    start_xfer(4, 100);
    @(negedge clk);
    if_b.buf_ack = 1'b0; if_b.buf_ready = 1'b1;
    repeat (3) @(negedge clk);
    if_b.buf_ready = 1'b0; if_b.buf_ack = 1'b1;
    @(negedge clk);
    if_b.buf_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total_n++; if (if_b.ack !== 1'b1) begin bad_n++; $display("FAIL idle_ack[%0d]: got %b want 1", c, if_b.ack); end
      total_n++; if (if_b.mem_addr !== 16'd103) begin bad_n++; $display("FAIL idle_addr[%0d]: got %0d want 103", c, if_b.mem_addr); end
      total_n++; if (if_b.buf_input !== 16'sd4) begin bad_n++; $display("FAIL idle_pix[%0d]: got %0d want 4", c, if_b.buf_input); end
      @(negedge clk);
    end
    if_b.buf_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    start_xfer(4, 100);
    @(negedge clk);
    if_b.buf_ack = 1'b0; if_b.buf_ready = 1'b1;
    repeat (7) @(negedge clk);
    #1;
    total_n++; if (if_b.buf_input !== 16'sd8) begin bad_n++; $display("FAIL mid_pix7: got %0d want 8", if_b.buf_input); end
    xrst = 1'b0;
    #1;
    total_n++; if (if_b.ack !== 1'b1) begin bad_n++; $display("FAIL mid_rst_ack: got %b want 1", if_b.ack); end
    total_n++; if (if_b.buf_req !== 1'b0) begin bad_n++; $display("FAIL mid_rst_buf_req: got %b want 0", if_b.buf_req); end
    total_n++; if (if_b.buf_input !== '0) begin bad_n++; $display("FAIL mid_rst_pix: got %0d want 0", if_b.buf_input); end
    total_n++; if (if_b.mem_addr !== '0) begin bad_n++; $display("FAIL mid_rst_addr: got %0d want 0", if_b.mem_addr); end
    @(negedge clk);
    xrst = 1'b1; if_b.buf_ready = 1'b0; if_b.buf_ack = 1'b1;
    start_xfer(4, 100);
    #1;
    total_n++; if (if_b.mem_addr !== 16'd100) begin bad_n++; $display("FAIL mid_restart_addr: got %0d want 100", if_b.mem_addr); end
    @(negedge clk);
    if_b.buf_ack = 1'b0; if_b.buf_ready = 1'b1;
    #1;
    total_n++; if (if_b.buf_input !== 16'sd1) begin bad_n++; $display("FAIL mid_restart_pix0: got %0d want 1", if_b.buf_input); end
    @(negedge clk); #1;
    total_n++; if (if_b.buf_input !== 16'sd2) begin bad_n++; $display("FAIL mid_restart_pix1: got %0d want 2", if_b.buf_input); end
    if_b.buf_ready = 1'b0; if_b.buf_ack = 1'b1;
    @(negedge clk); #1;
    total_n++; if (if_b.ack !== 1'b1) begin bad_n++; $display("FAIL mid_restart_ack: got %b want 1", if_b.ack); end
  endtask

  initial begin
    total_n = 0;
    bad_n   = 0;
    for (int i = 0; i < 65536; i++)
      mem[i] = (i >= 100 && i < 116) ? DWIDTH'(i - 99) : DWIDTH'(77);
    test_reset();
    test_stream_full();
    test_stream_toggle();
    test_double_req();
    test_zero_size();
    test_idle_ready();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
